// File: rtl/ha_result_accumulator_if.sv
// Handshake bundle between the halfAdder beat stream, the accumulator and the
// downstream result consumer. The master side feeds beats and accepts results;
// the slave side is the accumulator itself.
interface ha_result_accumulator_if #(
    parameter int ACC_W = 8,
    parameter int CNT_W = 4
);
    // Beat stream from the upstream halfAdder
    logic             sum_in;
    logic             carry_in;
    logic             last_in;
    logic             valid_in;
    logic             ready_out;

    // Frame result towards the reduction path
    logic [ACC_W-1:0] acc_out;
    logic [CNT_W-1:0] count_out;
    logic             overflow_out;
    logic             valid_out;
    logic             ready_in;

    modport master (
        output sum_in, carry_in, last_in, valid_in, ready_in,
        input  ready_out, acc_out, count_out, overflow_out, valid_out
    );

    modport slave (
        input  sum_in, carry_in, last_in, valid_in, ready_in,
        output ready_out, acc_out, count_out, overflow_out, valid_out
    );
endinterface

// File: rtl/ha_result_accumulator.sv
// Frame accumulator for the halfAdder result stream. Each accepted beat adds
// its {carry,sum} weight to a running total; a frame closes after BEATS beats
// or on an early last_in, and the total, beat count and sticky overflow are
// presented as one registered result while new beats are stalled.
module ha_result_accumulator #(
    parameter int BEATS = 8,
    parameter int ACC_W = 8
) (
    input logic                    clk,
    input logic                    rst,
    ha_result_accumulator_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Beat weight widened to the carry-out width of the accumulator adder.
    // A {1,1} beat is not a legal halfAdder output but is summed as 3 anyway.
    function automatic logic [ACC_W:0] beat_weight(input logic carry, input logic sum);
        beat_weight = {{(ACC_W-1){1'b0}}, carry, sum};
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             ovf_r;
    logic             ovf_next_s;
    logic [ACC_W-1:0] acc_out_r;
    logic [ACC_W-1:0] acc_out_next_s;
    logic [CNT_W-1:0] count_out_r;
    logic [CNT_W-1:0] count_out_next_s;
    logic             overflow_out_r;
    logic             overflow_out_next_s;
    logic             valid_out_r;
    logic             valid_out_next_s;
    logic             ready_out_r;
    logic             ready_out_next_s;

    logic [ACC_W:0]   sum_ext_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             accept_s;
    logic             frame_end_s;

    // ready_out is only ever high in ACCUM, so it alone qualifies acceptance
    assign sum_ext_s   = {1'b0, acc_r} + beat_weight(bus.carry_in, bus.sum_in);
    assign cnt_inc_s   = cnt_r + CNT_W'(1);
    assign accept_s    = bus.valid_in & ready_out_r;
    assign frame_end_s = accept_s & ((cnt_inc_s == BEATS_C) | bus.last_in);

    assign bus.ready_out    = ready_out_r;
    assign bus.valid_out    = valid_out_r;
    assign bus.acc_out      = acc_out_r;
    assign bus.count_out    = count_out_r;
    assign bus.overflow_out = overflow_out_r;

    // Next-state and next-output decode for the ACCUM/HOLD handshake machine
    always_comb begin
        state_next_s        = state_r;
        acc_next_s          = acc_r;
        cnt_next_s          = cnt_r;
        ovf_next_s          = ovf_r;
        acc_out_next_s      = acc_out_r;
        count_out_next_s    = count_out_r;
        overflow_out_next_s = overflow_out_r;
        valid_out_next_s    = valid_out_r;
        ready_out_next_s    = ready_out_r;

        case (state_r)
            ST_ACCUM: begin
                // Also raises ready_out on the first edge after reset release
                ready_out_next_s = 1'b1;
                valid_out_next_s = 1'b0;
                if (frame_end_s) begin
                    acc_out_next_s      = sum_ext_s[ACC_W-1:0];
                    count_out_next_s    = cnt_inc_s;
                    overflow_out_next_s = ovf_r | sum_ext_s[ACC_W];
                    valid_out_next_s    = 1'b1;
                    ready_out_next_s    = 1'b0;
                    state_next_s        = ST_HOLD;
                    acc_next_s          = {ACC_W{1'b0}};
                    cnt_next_s          = {CNT_W{1'b0}};
                    ovf_next_s          = 1'b0;
                end else if (accept_s) begin
                    acc_next_s = sum_ext_s[ACC_W-1:0];
                    cnt_next_s = cnt_inc_s;
                    ovf_next_s = ovf_r | sum_ext_s[ACC_W];
                end else begin
                    acc_next_s = acc_r;
                    cnt_next_s = cnt_r;
                    ovf_next_s = ovf_r;
                end
            end
            ST_HOLD: begin
                // Result registers stay untouched here, both while stalled and
                // after the transfer, so downstream sees a stable value
                if (bus.ready_in) begin
                    valid_out_next_s = 1'b0;
                    ready_out_next_s = 1'b1;
                    state_next_s     = ST_ACCUM;
                end else begin
                    valid_out_next_s = 1'b1;
                    ready_out_next_s = 1'b0;
                    state_next_s     = ST_HOLD;
                end
            end
            default: begin
                state_next_s     = ST_ACCUM;
                valid_out_next_s = 1'b0;
                ready_out_next_s = 1'b0;
                acc_next_s       = {ACC_W{1'b0}};
                cnt_next_s       = {CNT_W{1'b0}};
                ovf_next_s       = 1'b0;
            end
        endcase
    end

    // State, running frame totals and registered result/handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_ACCUM;
            acc_r          <= {ACC_W{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            ovf_r          <= 1'b0;
            acc_out_r      <= {ACC_W{1'b0}};
            count_out_r    <= {CNT_W{1'b0}};
            overflow_out_r <= 1'b0;
            valid_out_r    <= 1'b0;
            ready_out_r    <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            acc_r          <= acc_next_s;
            cnt_r          <= cnt_next_s;
            ovf_r          <= ovf_next_s;
            acc_out_r      <= acc_out_next_s;
            count_out_r    <= count_out_next_s;
            overflow_out_r <= overflow_out_next_s;
            valid_out_r    <= valid_out_next_s;
            ready_out_r    <= ready_out_next_s;
        end
    end
endmodule

// File: tb/tb_ha_result_accumulator.sv
// Directed bench for ha_result_accumulator. Three instances share one set of
// stimulus signals; sel picks which one sees valid_in/ready_in and whose
// outputs are compared. Instance 0 uses defaults, 1 has ACC_W=4, 2 has BEATS=1.
module tb_ha_result_accumulator;
    logic clk;
    logic rst;
    logic sum_d, carry_d, last_d, valid_d, ready_d;
    int   sel;
    int   errors;
    int   checks;

    logic ready_m, valid_m, ovf_m;
    int   acc_m, cnt_m;

    ha_result_accumulator_if #(.ACC_W(8), .CNT_W(4)) if0 ();
    ha_result_accumulator_if #(.ACC_W(4), .CNT_W(4)) if1 ();
    ha_result_accumulator_if #(.ACC_W(8), .CNT_W(1)) if2 ();

    ha_result_accumulator #(.BEATS(8), .ACC_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    ha_result_accumulator #(.BEATS(8), .ACC_W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    ha_result_accumulator #(.BEATS(1), .ACC_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.sum_in   = sum_d;
    assign if0.carry_in = carry_d;
    assign if0.last_in  = last_d;
    assign if0.valid_in = valid_d && (sel == 0);
    assign if0.ready_in = (sel == 0) ? ready_d : 1'b1;
    assign if1.sum_in   = sum_d;
    assign if1.carry_in = carry_d;
    assign if1.last_in  = last_d;
    assign if1.valid_in = valid_d && (sel == 1);
    assign if1.ready_in = (sel == 1) ? ready_d : 1'b1;
    assign if2.sum_in   = sum_d;
    assign if2.carry_in = carry_d;
    assign if2.last_in  = last_d;
    assign if2.valid_in = valid_d && (sel == 2);
    assign if2.ready_in = (sel == 2) ? ready_d : 1'b1;

    // Route the selected instance's outputs to the comparison signals
    always_comb begin
        ready_m = 1'b0;
        valid_m = 1'b0;
        ovf_m   = 1'b0;
        acc_m   = 0;
        cnt_m   = 0;
        case (sel)
            0: begin
                ready_m = if0.ready_out; valid_m = if0.valid_out; ovf_m = if0.overflow_out;
                acc_m = int'(if0.acc_out); cnt_m = int'(if0.count_out);
            end
            1: begin
                ready_m = if1.ready_out; valid_m = if1.valid_out; ovf_m = if1.overflow_out;
                acc_m = int'(if1.acc_out); cnt_m = int'(if1.count_out);
            end
            2: begin
                ready_m = if2.ready_out; valid_m = if2.valid_out; ovf_m = if2.overflow_out;
                acc_m = int'(if2.acc_out); cnt_m = int'(if2.count_out);
            end
            default: begin
                ready_m = 1'b0;
            end
        endcase
    end

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence itself stalls
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic s, c, l, v, ri;
        logic er, ev;
        int   acc, cnt;
        logic ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic c, input logic l, input logic v,
                                input logic ri, input logic er, input logic ev,
                                input int acc, input int cnt, input logic ovf);
        vec_t r;
        r.s = s; r.c = c; r.l = l; r.v = v; r.ri = ri;
        r.er = er; r.ev = ev; r.acc = acc; r.cnt = cnt; r.ovf = ovf;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present one beat and hold it until it has been accepted
    task automatic send_beat(input logic s, input logic c, input logic l);
        logic done;
        logic r;
        done = 1'b0;
        sum_d = s; carry_d = c; last_d = l; valid_d = 1'b1;
        for (int k = 0; k < 50; k++) begin
            r = ready_m;
            tick();
            if (r) begin
                done = 1'b1;
                break;
            end
        end
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_beat timeout: got ready=0 expected ready=1");
        end
    endtask

    // Wait for a result, compare it, then consume it with ready_in
    task automatic wait_result(input string name, input int acc, input int cnt, input logic ovf);
        for (int k = 0; k < 50; k++) begin
            if (valid_m) break;
            tick();
        end
        check({name, " valid"}, valid_m, 1);
        if (valid_m) begin
            check({name, " acc"}, acc_m, acc);
            check({name, " cnt"}, cnt_m, cnt);
            check({name, " ovf"}, ovf_m, ovf);
        end
        ready_d = 1'b1;
        tick();
        check({name, " valid_drop"}, valid_m, 0);
        check({name, " ready_back"}, ready_m, 1);
    endtask

    initial begin
        errors = 0; checks = 0; sel = 0;
        rst = 1'b0;
        sum_d = 1'b1; carry_d = 1'b0; last_d = 1'b0; valid_d = 1'b1; ready_d = 1'b0;

        // Reset held with a beat offered: nothing may move
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst ready", ready_m, 0);
            check("rst valid", valid_m, 0);
            check("rst acc", acc_m, 0);
            check("rst cnt", cnt_m, 0);
            check("rst ovf", ovf_m, 0);
        end
        rst = 1'b1;
        tick();
        check("release ready", ready_m, 1);
        check("release valid", valid_m, 0);
        // Beat still offered: exactly 8 more edges must close the frame
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k < 8) check("release early_valid", valid_m, 0);
        end
        check("release frame valid", valid_m, 1);
        check("release frame acc", acc_m, 8);
        check("release frame cnt", cnt_m, 8);
        check("release frame ovf", ovf_m, 0);
        valid_d = 1'b0; ready_d = 1'b1;
        tick();
        check("release xfer valid", valid_m, 0);
        check("release xfer ready", ready_m, 1);

        // Cycle-exact vectors: s c l v ri | ready valid acc cnt ovf
        for (int k = 0; k < 7; k++) vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 1, 16, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 1, 4, 3, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        for (int k = 0; k < 7; k++) vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 8, 8, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 1, 1, 0, 1, 6, 2, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 1, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            sum_d = vecs[i].s; carry_d = vecs[i].c; last_d = vecs[i].l;
            valid_d = vecs[i].v; ready_d = vecs[i].ri;
            tick();
            check($sformatf("vec%0d ready", i), ready_m, vecs[i].er);
            check($sformatf("vec%0d valid", i), valid_m, vecs[i].ev);
            if (vecs[i].ev) begin
                check($sformatf("vec%0d acc", i), acc_m, vecs[i].acc);
                check($sformatf("vec%0d cnt", i), cnt_m, vecs[i].cnt);
                check($sformatf("vec%0d ovf", i), ovf_m, vecs[i].ovf);
            end
        end
        valid_d = 1'b0; last_d = 1'b0;

        // Backpressure: result held while upstream keeps offering a beat
        ready_d = 1'b0;
        for (int k = 0; k < 8; k++) send_beat(1'b0, 1'b1, 1'b0);
        check("bp valid", valid_m, 1);
        check("bp acc", acc_m, 16);
        sum_d = 1'b1; carry_d = 1'b0; last_d = 1'b0; valid_d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bp hold valid", valid_m, 1);
            check("bp hold ready", ready_m, 0);
            check("bp hold acc", acc_m, 16);
            check("bp hold cnt", cnt_m, 8);
            check("bp hold ovf", ovf_m, 0);
        end
        ready_d = 1'b1;
        tick();
        check("bp xfer valid", valid_m, 0);
        check("bp xfer ready", ready_m, 1);
        tick();
        valid_d = 1'b0;
        for (int k = 0; k < 7; k++) send_beat(1'b1, 1'b0, 1'b0);
        wait_result("bp next", 8, 8, 1'b0);

        // Reset in the middle of a frame discards it
        for (int k = 0; k < 4; k++) send_beat(1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst ready", ready_m, 0);
        check("midrst valid", valid_m, 0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst after valid", valid_m, 0);
        for (int k = 0; k < 8; k++) send_beat(1'b1, 1'b0, 1'b0);
        wait_result("midrst frame", 8, 8, 1'b0);

        // Narrow accumulator wraps and flags overflow, then clears it
        sel = 1;
        ready_d = 1'b1;
        for (int k = 0; k < 8; k++) send_beat(1'b0, 1'b1, 1'b0);
        wait_result("ovf frame", 0, 8, 1'b1);
        send_beat(1'b1, 1'b0, 1'b0);
        send_beat(1'b1, 1'b0, 1'b1);
        wait_result("ovf next", 2, 2, 1'b0);

        // Single-beat frames
        sel = 2;
        send_beat(1'b1, 1'b1, 1'b0);
        wait_result("b1 first", 3, 1, 1'b0);
        send_beat(1'b0, 1'b1, 1'b0);
        wait_result("b1 second", 2, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ha_result_accumulator.md
Name: ha_result_accumulator

Overview:
Downstream consumer of the halfAdder stage. Takes the single-bit sum/carry stream over a valid/ready handshake and forms the per-beat value {carry,sum}. Accumulates that value over a frame of BEATS beats, or fewer if last_in ends the frame early. Emits the frame total, the beat count and an overflow flag over a second valid/ready handshake, for the axis_mul reduction path.

Parameters:
BEATS, 8, maximum beats per frame; range 1..255.
ACC_W, 8, accumulator/result width in bits; must be >= 2.
CNT_W, $clog2(BEATS+1), localparam, width of the beat counter and count_out.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset; asserted when 0
sum_in  input  1  sum bit from upstream halfAdder
carry_in  input  1  carry bit from upstream halfAdder
last_in  input  1  marks the final beat of a short frame; sampled only on an accepted beat
valid_in  input  1  upstream data valid
ready_out  output  1  this block can accept a beat
acc_out  output  ACC_W  frame total, modulo 2^ACC_W
count_out  output  CNT_W  number of beats accepted in the frame
overflow_out  output  1  total exceeded 2^ACC_W-1 during the frame
valid_out  output  1  result valid
ready_in  input  1  downstream accepts result

Behaviour:
- Reset (rst=0, async): state=ACCUM; ready_out=0, valid_out=0, acc_out=0, count_out=0, overflow_out=0; internal acc, beat counter and sticky overflow cleared.
- ready_out is registered. It rises on the first rising edge after rst deasserts.
- States: ACCUM (ready_out=1, valid_out=0) and HOLD (ready_out=0, valid_out=1).
- Accept: a beat is accepted when valid_in=1 and ready_out=1 at a rising edge.
- Beat weight is 2*carry_in + sum_in, range 0..3. The weight 3 (both bits 1) is not produced by a correct halfAdder but is added as 3 without flagging.
- On each accepted beat in ACCUM:
  - acc <= acc + weight (ACC_W-bit wrap).
  - The overflow sticky bit sets if the carry out of bit ACC_W-1 is 1.
  - cnt <= cnt + 1.
- Frame end: occurs on an accepted beat where cnt+1 == BEATS or last_in=1.
- Actions on frame end, all on the same edge:
  - acc_out is loaded with the updated total; count_out with cnt+1; overflow_out with the updated sticky bit.
  - valid_out <= 1, ready_out <= 0, state -> HOLD.
  - Internal acc, cnt and sticky bit clear.
- Latency: the result is valid the cycle after the final beat is accepted.
- In HOLD:
  - acc_out, count_out and overflow_out are held stable while valid_out=1 and ready_in=0, for any duration.
  - valid_in is ignored, so upstream must hold its beat.
- Output transfer: valid_out=1 and ready_in=1 at a rising edge.
  - valid_out <= 0, ready_out <= 1, state -> ACCUM.
  - Result registers keep their last value; downstream must not use them while valid_out=0.
  - There is no same-cycle pass-through: a beat presented in the transfer cycle is accepted no earlier than the next cycle.
- Minimum frame period is frame beats + 1 cycle. There is one bubble per frame.
- ready_in=1 while valid_out=0 has no effect.
- last_in=1 while valid_in=0 has no effect.
- Reset asserted mid-frame or in HOLD: the partial frame is discarded, with no output. After release the next frame starts with acc=0 and cnt=0.
- BEATS=1: every accepted beat ends a frame; count_out=1.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with valid_in=1 -> ready_out=0, valid_out=0, all outputs 0. Release -> ready_out=1 on the next edge; no beat is accepted before that edge.
2. Full frame, defaults: 8 beats of carry=1,sum=0, ready_in=1 -> one cycle after beat 8, valid_out=1, acc_out=16, count_out=8, overflow_out=0. valid_out is high for exactly 1 cycle; ready_out=1 on the next cycle.
3. Short frame: beats {sum=1}, {carry=1}, {sum=1,last_in=1} -> acc_out=4, count_out=3, overflow_out=0. The next frame restarts from 0: 8 beats of sum=1 gives acc_out=8.
4. Backpressure: complete a frame (acc_out=16) with ready_in=0 for 6 cycles while valid_in=1 with new data -> outputs stable, ready_out=0, no beat absorbed. ready_in=1 transfers; the held beat is accepted the following cycle.
5. Overflow (ACC_W=4): 8 beats of carry=1 -> acc_out=0 (16 mod 16), count_out=8, overflow_out=1. The next frame of 2 beats of sum=1 gives acc_out=2, overflow_out=0.
6. Reset mid-frame: accept 4 beats of carry=1, pulse rst=0 for 1 cycle, then send 8 beats of sum=1 -> acc_out=8, count_out=8, with no output from the aborted frame.
